// File: rtl/glyph_blit_engine_pkg.sv
// Shared geometry, widths and FSM encoding for the glyph blitter.
// The glyph ROM is 1 bit wide and holds GLYPHS*CELL_W*CELL_H bits.
package glyph_blit_engine_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CELL_W   = 10;
  localparam int CELL_H   = 10;
  localparam int ADDR_W   = 19;
  localparam int COL_W    = 8;
  localparam int GLYPHS   = 128;
  localparam int ROW_STEP = SCREEN_W - CELL_W + 1;
  localparam int CELLS_X  = SCREEN_W / CELL_W;
  localparam int CELLS_Y  = SCREEN_H / CELL_H;
  localparam int GLYPH_W  = $clog2(GLYPHS);
  localparam int ROM_AW   = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // glyph*100 as shift-add: 64 + 32 + 4.
  function automatic logic [ROM_AW-1:0] glyph_base(input logic [GLYPH_W-1:0] g);
    logic [ROM_AW-1:0] w;
    w = ROM_AW'(g);
    return (w << 6) + (w << 5) + (w << 2);
  endfunction

endpackage

// File: rtl/glyph_blit_engine_cell_origin_calc.sv
// Combinational cell -> linear origin (y*6400 + x*10) plus range check.
// Shift-add only; no multiplier or divider.
module glyph_blit_engine_cell_origin_calc
  import glyph_blit_engine_pkg::*;
(
  input  logic [5:0]        i_cell_x,
  input  logic [5:0]        i_cell_y,
  output logic [ADDR_W-1:0] o_origin,
  output logic              o_range_ok
);

  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;

  assign w_x = ADDR_W'(i_cell_x);
  assign w_y = ADDR_W'(i_cell_y);

  // 6400 = 4096 + 2048 + 256, 10 = 8 + 2
  assign o_origin   = (w_y << 12) + (w_y << 11) + (w_y << 8) + (w_x << 3) + (w_x << 1);
  assign o_range_ok = (int'(i_cell_x) < CELLS_X) && (int'(i_cell_y) < CELLS_Y);

endmodule

// File: rtl/glyph_blit_engine.sv
// Draws one 10x10 glyph as 100 linear frame-buffer writes, one ROM read per pixel.
// ROM output and the write stage stall together whenever a write is held by pix_ready.
module glyph_blit_engine
  import glyph_blit_engine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [5:0]         cell_x,
  input  logic [5:0]         cell_y,
  input  logic [GLYPH_W-1:0] glyph,
  input  logic [COL_W-1:0]   fg_colour,
  input  logic [COL_W-1:0]   bg_colour,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic               rom_data,
  output logic               pix_we,
  input  logic               pix_ready,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COL_W-1:0]   pix_data,
  output logic               done,
  output logic               err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_col;
  logic [3:0]        r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [COL_W-1:0]  r_fg;
  logic [COL_W-1:0]  r_bg;
  logic              r_pix_we;
  logic              r_err;

  logic              w_accept;
  logic              w_advance;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_range_ok;
  logic [ADDR_W-1:0] w_origin;

  glyph_blit_engine_cell_origin_calc u_cell_origin_calc (
    .i_cell_x   (cell_x),
    .i_cell_y   (cell_y),
    .o_origin   (w_origin),
    .o_range_ok (w_range_ok)
  );

  assign w_accept     = start_valid && (r_state == ST_IDLE);
  assign w_advance    = !r_pix_we || pix_ready;
  assign w_issue      = (r_state == ST_RUN) && w_advance;
  assign w_last_issue = w_issue && (r_col == 4'(CELL_W - 1)) && (r_row == 4'(CELL_H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    rom_en      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_state_nxt = w_range_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        rom_en = w_advance;
        if (w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_advance) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_pix_addr <= '0;
      r_rom_addr <= '0;
      r_fg       <= '0;
      r_bg       <= '0;
      r_pix_we   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col      <= '0;
        r_row      <= '0;
        r_addr     <= w_origin;
        r_rom_addr <= glyph_base(glyph);
        r_fg       <= fg_colour;
        r_bg       <= bg_colour;
        r_err      <= !w_range_ok;
      end else if (w_issue) begin
        // End of a glyph row jumps to the first column of the next screen line.
        if (r_col == 4'(CELL_W - 1)) begin
          r_col  <= '0;
          r_row  <= r_row + 4'd1;
          r_addr <= r_addr + ADDR_W'(ROW_STEP);
        end else begin
          r_col  <= r_col + 4'd1;
          r_addr <= r_addr + ADDR_W'(1);
        end
        r_rom_addr <= r_rom_addr + ROM_AW'(1);
      end
      // Stage 1 tracks the pixel whose ROM bit is currently on rom_data.
      if (w_advance) begin
        r_pix_we   <= w_issue;
        r_pix_addr <= r_addr;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign pix_we   = r_pix_we;
  assign pix_addr = r_pix_addr;
  assign pix_data = rom_data ? r_fg : r_bg;

endmodule

// File: tb/tb_glyph_blit_engine.sv
// Directed bench for glyph_blit_engine with a registered ROM model and write logger.
module tb_glyph_blit_engine;
  import glyph_blit_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [5:0]  cell_x;
  logic [5:0]  cell_y;
  logic [6:0]  glyph;
  logic [7:0]  fg_colour;
  logic [7:0]  bg_colour;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic        rom_data = 1'b0;
  logic        pix_we;
  logic        pix_ready;
  logic [18:0] pix_addr;
  logic [7:0]  pix_data;
  logic        done;
  logic        err;

  glyph_blit_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .glyph       (glyph),
    .fg_colour   (fg_colour),
    .bg_colour   (bg_colour),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_we      (pix_we),
    .pix_ready   (pix_ready),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rom_mem [0:12799];
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  bit rand_mode = 1'b0;
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Logger: a negedge sample reflects what the DUT presents at the next posedge.
  int          clr_epoch = 0;
  int          seen_epoch = 0;
  int          n_rom = 0, n_stall = 0, stab_err = 0;
  int          rom_first_edge, rom_last_edge, we_first_edge, we_last_edge;
  logic [13:0] rom_first_addr, rom_last_addr;
  logic [18:0] wa [$];
  logic [7:0]  wd [$];
  bit          prev_stall = 1'b0;
  logic [18:0] prev_a;
  logic [7:0]  prev_d;

  always @(negedge clk) begin
    if (seen_epoch != clr_epoch) begin
      seen_epoch = clr_epoch;
      n_rom = 0; n_stall = 0; stab_err = 0; prev_stall = 1'b0;
      wa.delete(); wd.delete();
    end
    if (rom_en) begin
      if (n_rom == 0) begin rom_first_edge = cyc + 1; rom_first_addr = rom_addr; end
      rom_last_edge = cyc + 1; rom_last_addr = rom_addr; n_rom++;
    end
    if (pix_we && pix_ready) begin
      if (wa.size() == 0) we_first_edge = cyc + 1;
      we_last_edge = cyc + 1;
      wa.push_back(pix_addr); wd.push_back(pix_data);
    end
    if (prev_stall && !(pix_we && pix_addr == prev_a && pix_data == prev_d)) stab_err++;
    if (pix_we && !pix_ready) n_stall++;
    prev_stall = pix_we && !pix_ready;
    prev_a = pix_addr; prev_d = pix_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr_epoch++;
    @(negedge clk); #1;
  endtask

  task automatic send(input int x, input int y, input int g, input int fg, input int bg,
                      output int acc_edge);
    @(negedge clk);
    check("ready_before_accept", start_ready, 1);
    cell_x = 6'(x); cell_y = 6'(y); glyph = 7'(g);
    fg_colour = 8'(fg); bg_colour = 8'(bg);
    start_valid = 1'b1;
    acc_edge = cyc + 1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int d_edge, output logic d_err);
    d_edge = -1; d_err = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin d_edge = cyc + 1; d_err = err; break; end
      @(negedge clk);
    end
  endtask

  task automatic verify_writes(input string tag, input int x, input int y, input int g,
                               input int fg, input int bg);
    int n;
    int ea, ed;
    n = wa.size();
    check({tag, "_count"}, n, 100);
    for (int i = 0; i < n && i < 100; i++) begin
      ea = y * 6400 + x * 10 + (i / 10) * 640 + (i % 10);
      ed = rom_mem[g * 100 + i] ? fg : bg;
      check({tag, "_addr"}, wa[i], ea);
      check({tag, "_data"}, wd[i], ed);
    end
  endtask

  int   n_acc, d_edge;
  logic d_err;
  int   ill_y [2] = '{48, 63};
  int   ill_x [2] = '{0, 5};

  initial begin
    reset = 1'b1; start_valid = 1'b0;
    cell_x = '0; cell_y = '0; glyph = '0; fg_colour = '0; bg_colour = '0;
    for (int i = 0; i < 12800; i++) rom_mem[i] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_rom_en", rom_en, 0);
    check("rst_pix_we", pix_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Cell (0,0), glyph 0, all-ones ROM, no stalls.
    clear_log();
    send(0, 0, 0, 8'hA5, 8'h3C, n_acc);
    wait_done(d_edge, d_err);
    check("t1_done_edge", d_edge, n_acc + 102);
    check("t1_err", d_err, 0);
    check("t1_ready_at_done", start_ready, 0);
    check("t1_rom_count", n_rom, 100);
    check("t1_rom_first_edge", rom_first_edge, n_acc + 1);
    check("t1_rom_last_edge", rom_last_edge, n_acc + 100);
    check("t1_we_first_edge", we_first_edge, n_acc + 2);
    check("t1_we_last_edge", we_last_edge, n_acc + 101);
    if (wa.size() == 100) begin
      check("t1_addr9", wa[9], 9);
      check("t1_addr10", wa[10], 640);
      check("t1_addr99", wa[99], 5769);
    end
    verify_writes("t1", 0, 0, 0, 8'hA5, 8'h3C);
    @(negedge clk);
    check("t1_ready_after", start_ready, 1);
    check("t1_done_pulse", done, 0);

    // Bottom-right cell, last glyph, random ROM contents.
    for (int i = 0; i < 12800; i++) rom_mem[i] = 1'($urandom_range(0, 1));
    clear_log();
    send(63, 47, 127, 8'h11, 8'hEE, n_acc);
    wait_done(d_edge, d_err);
    check("t2_done_edge", d_edge, n_acc + 102);
    check("t2_err", d_err, 0);
    check("t2_rom_first", rom_first_addr, 12700);
    check("t2_rom_last", rom_last_addr, 12799);
    if (wa.size() == 100) begin
      check("t2_first_addr", wa[0], 301430);
      check("t2_last_addr", wa[99], 307199);
    end
    verify_writes("t2", 63, 47, 127, 8'h11, 8'hEE);

    // Out-of-range rows.
    for (int k = 0; k < 2; k++) begin
      clear_log();
      send(ill_x[k], ill_y[k], 5, 8'h01, 8'h02, n_acc);
      wait_done(d_edge, d_err);
      check("ill_done_edge", d_edge, n_acc + 1);
      check("ill_err", d_err, 1);
      repeat (3) @(negedge clk);
      check("ill_rom_count", n_rom, 0);
      check("ill_write_count", wa.size(), 0);
      check("ill_ready", start_ready, 1);
    end

    // Random backpressure plus an ignored request while busy.
    rand_mode = 1'b1;
    clear_log();
    send(20, 10, 3, 8'h5A, 8'hC3, n_acc);
    repeat (15) @(negedge clk);
    cell_x = 6'd1; cell_y = 6'd1; glyph = 7'd9; start_valid = 1'b1;
    repeat (3) @(negedge clk);
    start_valid = 1'b0;
    wait_done(d_edge, d_err);
    rand_mode = 1'b0;
    check("t4_done_seen", d_edge > 0, 1);
    check("t4_err", d_err, 0);
    check("t4_stall_stable", stab_err, 0);
    check("t4_stalls_seen", n_stall > 0, 1);
    verify_writes("t4", 20, 10, 3, 8'h5A, 8'hC3);
    repeat (2) @(negedge clk);

    // Reset in the middle of a draw.
    clear_log();
    send(1, 1, 0, 8'h77, 8'h88, n_acc);
    for (int i = 0; i < 500; i++) begin
      if (wa.size() >= 37) break;
      @(negedge clk); #1;
    end
    check("t5_reached_px37", wa.size(), 37);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_pix_we", pix_we, 0);
    check("t5_rst_ready", start_ready, 1);
    check("t5_rst_rom_en", rom_en, 0);
    check("t5_rst_done", done, 0);
    reset = 1'b0;

    // Checkerboard glyph at cell (5,5).
    for (int i = 0; i < 100; i++) rom_mem[200 + i] = 1'(((i / 10) + (i % 10)) & 1);
    clear_log();
    send(5, 5, 2, 8'hFF, 8'h00, n_acc);
    wait_done(d_edge, d_err);
    check("t6_done_edge", d_edge, n_acc + 102);
    check("t6_err", d_err, 0);
    if (wa.size() == 100) begin
      check("t6_first_addr", wa[0], 32050);
      check("t6_first_data", wd[0], 8'h00);
      check("t6_second_data", wd[1], 8'hFF);
      for (int i = 0; i < 100; i++) begin
        check("t6_x", wa[i] % 640, 50 + i % 10);
        check("t6_y", wa[i] / 640, 50 + i / 10);
        if (i % 10 != 0) check("t6_alternate", wd[i] ^ wd[i - 1], 8'hFF);
      end
    end
    verify_writes("t6", 5, 5, 2, 8'hFF, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
